// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, captures the instruction word into IF/ID and applies
// decode-stage redirects (jr > jump > branch) with a one-bubble flush.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    input  logic        stall,
    input  logic        redir_jump,
    input  logic        redir_jr,
    input  logic        redir_branch,
    input  logic [31:0] jr_target,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid,
    output logic        misaligned
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        id_valid_q, id_valid_d;
    logic        misaligned_q, misaligned_d;

    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [31:0] jr_aligned;
    logic [31:0] redir_target;
    logic        redir_req;
    logic        redir_take;

    // Targets are derived from the instruction sitting in decode, not the one being fetched.
    always_comb begin
        jump_target   = {id_pc_plus4_q[31:28], id_instr_q[25:0], 2'b00};
        branch_target = id_pc_plus4_q + {{14{id_instr_q[15]}}, id_instr_q[15:0], 2'b00};
        jr_aligned    = {jr_target[31:2], 2'b00};
        redir_req     = redir_jr | redir_jump | redir_branch;
        redir_take    = redir_req & id_valid_q & ~stall;
        if (redir_jr) begin
            redir_target = jr_aligned;
        end else if (redir_jump) begin
            redir_target = jump_target;
        end else begin
            redir_target = branch_target;
        end
    end

    always_comb begin
        pc_d          = pc_q;
        id_instr_d    = id_instr_q;
        id_pc_plus4_d = id_pc_plus4_q;
        id_valid_d    = id_valid_q;
        misaligned_d  = misaligned_q;
        if (!stall) begin
            if (redir_take) begin
                // The word fetched this cycle is wrong-path; replace it with a bubble.
                pc_d       = redir_target;
                id_instr_d = 32'h0000_0000;
                id_valid_d = 1'b0;
                if (redir_jr && (jr_target[1:0] != 2'b00)) begin
                    misaligned_d = 1'b1;
                end
            end else begin
                pc_d          = pc_q + 32'd4;
                id_instr_d    = imem_data;
                id_pc_plus4_d = pc_q + 32'd4;
                id_valid_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            id_instr_q    <= 32'h0000_0000;
            id_pc_plus4_q <= 32'h0000_0000;
            id_valid_q    <= 1'b0;
            misaligned_q  <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            id_instr_q    <= id_instr_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_valid_q    <= id_valid_d;
            misaligned_q  <= misaligned_d;
        end
    end

    assign pc          = pc_q;
    assign id_instr    = id_instr_q;
    assign id_pc_plus4 = id_pc_plus4_q;
    assign id_valid    = id_valid_q;
    assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed walk plus a random phase, each edge's expected
// IF state pushed to a scoreboard when driven and popped/compared after the edge.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, stall, redir_jump, redir_jr, redir_branch;
    logic [31:0] jr_target, imem_data, pc, id_instr, id_pc_plus4;
    logic        id_valid, misaligned;
    logic [31:0] mem [256];

    assign imem_data = mem[pc[9:2]];

    instruction_fetch dut (
        .clk(clk), .reset(reset), .imem_data(imem_data), .pc(pc), .stall(stall),
        .redir_jump(redir_jump), .redir_jr(redir_jr), .redir_branch(redir_branch),
        .jr_target(jr_target), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
        .id_valid(id_valid), .misaligned(misaligned)
    );

    // Second instance exercising a non-zero reset vector.
    logic        reset2;
    logic        tie0 = 1'b0;
    logic [31:0] tie0_w = 32'h0;
    logic [31:0] imem_data2, pc2, id_instr2, id_pc_plus4_2;
    logic        id_valid2, misaligned2;

    assign imem_data2 = mem[pc2[9:2]];

    instruction_fetch #(.RESET_PC(32'h0000_0400)) dut2 (
        .clk(clk), .reset(reset2), .imem_data(imem_data2), .pc(pc2), .stall(tie0),
        .redir_jump(tie0), .redir_jr(tie0), .redir_branch(tie0),
        .jr_target(tie0_w), .id_instr(id_instr2), .id_pc_plus4(id_pc_plus4_2),
        .id_valid(id_valid2), .misaligned(misaligned2)
    );

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_mis;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic st, input logic rj, input logic rjr,
                              input logic rb, input logic [31:0] jrt);
        logic [31:0] tgt;
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
        end else if (st) begin
            // everything holds
        end else if (m_valid && (rj || rjr || rb)) begin
            if (rjr)     tgt = jrt & 32'hFFFF_FFFC;
            else if (rj) tgt = {m_pc4[31:28], m_instr[25:0], 2'b00};
            else         tgt = m_pc4 + {{14{m_instr[15]}}, m_instr[15:0], 2'b00};
            if (rjr && (jrt[1:0] != 2'b00)) m_mis = 1'b1;
            m_pc = tgt; m_instr = 32'h0; m_valid = 1'b0;
        end else begin
            m_instr = mem[m_pc[9:2]];
            m_pc4   = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
            m_valid = 1'b1;
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic st, input logic rj,
                        input logic rjr, input logic rb, input logic [31:0] jrt);
        exp_t e;
        reset = rst; stall = st; redir_jump = rj; redir_jr = rjr; redir_branch = rb;
        jr_target = jrt;
        model_edge(rst, st, rj, rjr, rb, jrt);
        e.tag = tag; e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4;
        e.valid = m_valid; e.mis = m_mis;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_val({e.tag, "_pc"},    pc,          e.pc);
        check_val({e.tag, "_instr"}, id_instr,    e.instr);
        check_val({e.tag, "_pc4"},   id_pc_plus4, e.pc4);
        check_val({e.tag, "_valid"}, {31'h0, id_valid},   {31'h0, e.valid});
        check_val({e.tag, "_mis"},   {31'h0, misaligned}, {31'h0, e.mis});
    endtask

    task automatic go(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic jr_to(input string tag, input logic [31:0] t);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0]   = 32'h0c00_0006;
        mem[1]   = 32'h0800_0003;
        mem[2]   = 32'h0800_0005;
        mem[5]   = 32'h150a_0013;
        mem[6]   = 32'h2008_0001;
        mem[9]   = 32'h2129_0004;
        mem[10]  = 32'h380c_0020;
        mem[255] = 32'h0000_0000;

        reset = 1'b1; stall = 1'b0; redir_jump = 1'b0; redir_jr = 1'b0;
        redir_branch = 1'b0; jr_target = 32'h0; reset2 = 1'b1;
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
        #2;

        // reset and first fetch
        step("rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_val("rst_pc_const", pc, 32'h0);
        go("fetch0");
        check_val("fetch0_instr_const", id_instr, 32'h0c00_0006);
        check_val("fetch0_pc_const", pc, 32'h4);

        // jump from decode
        step("jump", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_val("jump_pc_const", pc, 32'h18);
        go("jump_land");
        check_val("jump_land_instr_const", id_instr, 32'h2008_0001);
        check_val("jump_land_pc4_const", id_pc_plus4, 32'h1C);

        // taken branch, then not taken
        jr_to("jr14", 32'h14);
        go("bne_f");
        step("br_taken", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        check_val("br_taken_pc_const", pc, 32'h64);
        go("br_land");
        jr_to("jr14b", 32'h14);
        go("bne_f2");
        go("br_nt");
        check_val("br_nt_pc_const", pc, 32'h1C);

        // stall hold, stall beats redirect
        jr_to("jr24", 32'h24);
        go("f24");
        for (int i = 0; i < 3; i++) step("stall", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step("stall_jump", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check_val("stall_pc_const", pc, 32'h28);
        go("unstall");
        check_val("unstall_instr_const", id_instr, 32'h380c_0020);
        check_val("unstall_pc_const", pc, 32'h2C);

        // all redirects together, misaligned jr target
        step("all_redir", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0103);
        check_val("all_redir_pc_const", pc, 32'h100);
        check_val("all_redir_mis_const", {31'h0, misaligned}, 32'h1);
        go("mis_hold0");
        go("mis_hold1");
        step("mis_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step("bubble_jump", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_val("bubble_jump_pc_const", pc, 32'h4);

        // PC wrap
        go("pre_wrap");
        jr_to("jr_top", 32'hFFFF_FFFC);
        go("wrap");
        check_val("wrap_pc_const", pc, 32'h0);

        // mid-stream reset during stall and during a redirect
        go("ms0");
        step("rst_stall", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        go("ms1");
        step("rst_redir", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0002);
        go("restart");
        check_val("restart_pc_const", pc, 32'h4);

        // random phase
        for (int i = 0; i < 80; i++) begin
            step("rnd", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 4) == 0), {22'h0, 10'($urandom_range(0, 1023))});
        end

        // non-zero reset vector
        check_val("rv_rst_pc", pc2, 32'h400);
        check_val("rv_rst_valid", {31'h0, id_valid2}, 32'h0);
        reset2 = 1'b0;
        @(posedge clk); #1;
        check_val("rv_fetch_pc", pc2, 32'h404);
        check_val("rv_fetch_pc4", id_pc_plus4_2, 32'h404);
        check_val("rv_fetch_instr", id_instr2, mem[0]);
        check_val("rv_fetch_valid", {31'h0, id_valid2}, 32'h1);
        reset2 = 1'b1;
        @(posedge clk); #1;
        check_val("rv_rerst_pc", pc2, 32'h400);
        check_val("rv_rerst_instr", id_instr2, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
